// File: rtl/syn_lb_arb_pkg.sv
// Shared types and constants for the local-bus round-robin arbiter.
// Imported by the arbiter top and its round-robin picker.
package syn_lb_arb_pkg;

    localparam int MAX_MASTERS = 8;
    localparam int IDX_W       = 3;

    localparam logic [31:0] LB_TIMEOUT_DATA = 32'hDEAD_DEAD;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_e;

    typedef enum logic {
        OP_RD,
        OP_WR
    } op_e;

endpackage

// File: rtl/syn_rr_picker.sv
// Combinational round-robin select: the first requester found when searching
// upward from rr_ptr+1, wrapping at NUM_MASTERS.
module syn_rr_picker
    import syn_lb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       rr_ptr,
    output logic [IDX_W-1:0]       winner,
    output logic                   any_req
);

    logic [MAX_MASTERS-1:0] req_ext;
    logic [IDX_W-1:0]       cand [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] hit;

    assign req_ext = MAX_MASTERS'(req);

    // cand[gi] is the master examined at search distance gi+1 from rr_ptr
    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_cand
            logic [IDX_W:0] sum;
            assign sum      = {1'b0, rr_ptr} + (IDX_W+1)'(gi + 1);
            assign cand[gi] = (sum >= (IDX_W+1)'(NUM_MASTERS))
                            ? IDX_W'(sum - (IDX_W+1)'(NUM_MASTERS))
                            : sum[IDX_W-1:0];
            assign hit[gi]  = req_ext[cand[gi]];
        end
    endgenerate

    always_comb begin
        winner  = '0;
        any_req = |req;
        // Walk from the farthest candidate back so the nearest hit wins
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            if (hit[k]) begin
                winner = cand[k];
            end
        end
    end

endmodule

// File: rtl/syn_lb_arbiter.sv
// Round-robin arbiter sharing one cortex local-bus slave port between several
// LB masters: one transaction at a time, response routed back, hung slaves timed out.
module syn_lb_arbiter
    import syn_lb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int LB_DATA_W   = 32,
    parameter int LB_ADDR_W   = 16,
    parameter int TIMEOUT_W   = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_MASTERS-1:0]           m_wr_en,
    input  logic [NUM_MASTERS-1:0]           m_rd_en,
    input  logic [NUM_MASTERS*LB_ADDR_W-1:0] m_addr,
    input  logic [NUM_MASTERS*LB_DATA_W-1:0] m_wr_data,
    output logic [NUM_MASTERS-1:0]           m_wr_valid,
    output logic [NUM_MASTERS-1:0]           m_rd_valid,
    output logic [LB_DATA_W-1:0]             m_rd_data,
    output logic                             lb_wr_en,
    output logic                             lb_rd_en,
    output logic [LB_ADDR_W-1:0]             lb_addr,
    output logic [LB_DATA_W-1:0]             lb_wr_data,
    input  logic                             lb_wr_valid,
    input  logic                             lb_rd_valid,
    input  logic [LB_DATA_W-1:0]             lb_rd_data,
    output logic                             timeout_err,
    output logic [2:0]                       grant_idx
);

    state_e                 state_reg, state_next;
    op_e                    op_reg, op_next;
    logic [IDX_W-1:0]       rr_ptr_reg, rr_ptr_next;
    logic [IDX_W-1:0]       grant_reg, grant_next;
    logic [TIMEOUT_W-1:0]   cnt_reg, cnt_next, cnt_inc;
    logic                   lb_wr_en_reg, lb_wr_en_next;
    logic                   lb_rd_en_reg, lb_rd_en_next;
    logic [LB_ADDR_W-1:0]   lb_addr_reg, lb_addr_next;
    logic [LB_DATA_W-1:0]   lb_wr_data_reg, lb_wr_data_next;
    logic [NUM_MASTERS-1:0] m_wr_valid_reg, m_wr_valid_next;
    logic [NUM_MASTERS-1:0] m_rd_valid_reg, m_rd_valid_next;
    logic [LB_DATA_W-1:0]   m_rd_data_reg, m_rd_data_next;
    logic                   timeout_err_reg, timeout_err_next;

    logic [NUM_MASTERS-1:0] req;
    logic [IDX_W-1:0]       winner;
    logic                   any_req;
    logic [MAX_MASTERS-1:0] wr_ext;
    logic [LB_ADDR_W-1:0]   addr_arr [MAX_MASTERS];
    logic [LB_DATA_W-1:0]   data_arr [MAX_MASTERS];
    logic [NUM_MASTERS-1:0] grant_onehot;

    assign req          = m_wr_en | m_rd_en;
    assign wr_ext       = MAX_MASTERS'(m_wr_en);
    assign cnt_inc      = cnt_reg + TIMEOUT_W'(1);
    assign grant_onehot = NUM_MASTERS'(1) << grant_reg;

    // Unpack the master buses, padding unused slots so a 3-bit index is always legal
    genvar gi;
    generate
        for (gi = 0; gi < MAX_MASTERS; gi++) begin : g_bus
            if (gi < NUM_MASTERS) begin : g_used
                assign addr_arr[gi] = m_addr[gi*LB_ADDR_W +: LB_ADDR_W];
                assign data_arr[gi] = m_wr_data[gi*LB_DATA_W +: LB_DATA_W];
            end else begin : g_pad
                assign addr_arr[gi] = '0;
                assign data_arr[gi] = '0;
            end
        end
    endgenerate

    syn_rr_picker #(
        .NUM_MASTERS(NUM_MASTERS)
    ) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr_reg),
        .winner (winner),
        .any_req(any_req)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            op_reg          <= OP_RD;
            rr_ptr_reg      <= IDX_W'(NUM_MASTERS - 1);
            grant_reg       <= '0;
            cnt_reg         <= '0;
            lb_wr_en_reg    <= 1'b0;
            lb_rd_en_reg    <= 1'b0;
            lb_addr_reg     <= '0;
            lb_wr_data_reg  <= '0;
            m_wr_valid_reg  <= '0;
            m_rd_valid_reg  <= '0;
            m_rd_data_reg   <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            op_reg          <= op_next;
            rr_ptr_reg      <= rr_ptr_next;
            grant_reg       <= grant_next;
            cnt_reg         <= cnt_next;
            lb_wr_en_reg    <= lb_wr_en_next;
            lb_rd_en_reg    <= lb_rd_en_next;
            lb_addr_reg     <= lb_addr_next;
            lb_wr_data_reg  <= lb_wr_data_next;
            m_wr_valid_reg  <= m_wr_valid_next;
            m_rd_valid_reg  <= m_rd_valid_next;
            m_rd_data_reg   <= m_rd_data_next;
            timeout_err_reg <= timeout_err_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        op_next          = op_reg;
        rr_ptr_next      = rr_ptr_reg;
        grant_next       = grant_reg;
        cnt_next         = cnt_reg;
        lb_wr_en_next    = 1'b0;
        lb_rd_en_next    = 1'b0;
        lb_addr_next     = lb_addr_reg;
        lb_wr_data_next  = lb_wr_data_reg;
        m_wr_valid_next  = '0;
        m_rd_valid_next  = '0;
        m_rd_data_next   = m_rd_data_reg;
        timeout_err_next = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (any_req) begin
                    grant_next      = winner;
                    rr_ptr_next     = winner;
                    lb_addr_next    = addr_arr[winner];
                    lb_wr_data_next = data_arr[winner];
                    op_next         = wr_ext[winner] ? OP_WR : OP_RD;
                    lb_wr_en_next   = wr_ext[winner];
                    lb_rd_en_next   = ~wr_ext[winner];
                    state_next      = ISSUE;
                end
            end
            ISSUE: begin
                cnt_next   = '0;
                state_next = WAIT;
            end
            WAIT: begin
                if ((op_reg == OP_WR && lb_wr_valid) || (op_reg == OP_RD && lb_rd_valid)) begin
                    if (op_reg == OP_WR) begin
                        m_wr_valid_next = grant_onehot;
                    end else begin
                        m_rd_valid_next = grant_onehot;
                        m_rd_data_next  = lb_rd_data;
                    end
                    state_next = DONE;
                end else if (cnt_inc == '1) begin
                    // Slave is hung: complete the transaction with an error response
                    if (op_reg == OP_WR) begin
                        m_wr_valid_next = grant_onehot;
                    end else begin
                        m_rd_valid_next = grant_onehot;
                        m_rd_data_next  = LB_DATA_W'(LB_TIMEOUT_DATA);
                    end
                    timeout_err_next = 1'b1;
                    state_next       = DONE;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign m_wr_valid  = m_wr_valid_reg;
    assign m_rd_valid  = m_rd_valid_reg;
    assign m_rd_data   = m_rd_data_reg;
    assign lb_wr_en    = lb_wr_en_reg;
    assign lb_rd_en    = lb_rd_en_reg;
    assign lb_addr     = lb_addr_reg;
    assign lb_wr_data  = lb_wr_data_reg;
    assign timeout_err = timeout_err_reg;
    assign grant_idx   = grant_reg;

endmodule

// File: tb/tb_syn_lb_arbiter.sv
// Scoreboard bench for syn_lb_arbiter: directed master requests, a simple slave
// model, and monitors that check bus strobes and master responses against queues.
module tb_syn_lb_arbiter;

    localparam int NM = 2;
    localparam int AW = 16;
    localparam int DW = 32;

    logic              clk;
    logic              rst;
    logic [NM-1:0]     m_wr_en;
    logic [NM-1:0]     m_rd_en;
    logic [NM*AW-1:0]  m_addr;
    logic [NM*DW-1:0]  m_wr_data;
    logic [NM-1:0]     m_wr_valid;
    logic [NM-1:0]     m_rd_valid;
    logic [DW-1:0]     m_rd_data;
    logic              lb_wr_en;
    logic              lb_rd_en;
    logic [AW-1:0]     lb_addr;
    logic [DW-1:0]     lb_wr_data;
    logic              lb_wr_valid;
    logic              lb_rd_valid;
    logic [DW-1:0]     lb_rd_data;
    logic              timeout_err;
    logic [2:0]        grant_idx;

    syn_lb_arbiter #(
        .NUM_MASTERS(NM),
        .LB_DATA_W  (DW),
        .LB_ADDR_W  (AW),
        .TIMEOUT_W  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .m_wr_en    (m_wr_en),
        .m_rd_en    (m_rd_en),
        .m_addr     (m_addr),
        .m_wr_data  (m_wr_data),
        .m_wr_valid (m_wr_valid),
        .m_rd_valid (m_rd_valid),
        .m_rd_data  (m_rd_data),
        .lb_wr_en   (lb_wr_en),
        .lb_rd_en   (lb_rd_en),
        .lb_addr    (lb_addr),
        .lb_wr_data (lb_wr_data),
        .lb_wr_valid(lb_wr_valid),
        .lb_rd_valid(lb_rd_valid),
        .lb_rd_data (lb_rd_data),
        .timeout_err(timeout_err),
        .grant_idx  (grant_idx)
    );

    typedef struct {
        bit          is_wr;
        int          idx;
        logic [15:0] addr;
        logic [31:0] data;
    } lb_exp_t;

    typedef struct {
        bit          is_wr;
        int          idx;
        logic [31:0] data;
        bit          tmo;
        int          lat;
    } rsp_exp_t;

    lb_exp_t  lb_q[$];
    rsp_exp_t rsp_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int last_strobe = -100;
    int lb_cnt      = 0;
    int rsp_cnt     = 0;

    int          slave_delay = 1;
    bit          slave_mute  = 0;
    logic [31:0] slave_data  = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_lb(input bit w, input int i, input logic [15:0] a, input logic [31:0] d);
        lb_exp_t e;
        e.is_wr = w; e.idx = i; e.addr = a; e.data = d;
        lb_q.push_back(e);
    endtask

    task automatic push_rsp(input bit w, input int i, input logic [31:0] d, input bit t, input int l);
        rsp_exp_t e;
        e.is_wr = w; e.idx = i; e.data = d; e.tmo = t; e.lat = l;
        rsp_q.push_back(e);
    endtask

    task automatic set_master(input int i, input bit w, input bit r,
                              input logic [15:0] a, input logic [31:0] d);
        m_wr_en[i]          = w;
        m_rd_en[i]          = r;
        m_addr[i*AW +: AW]  = a;
        m_wr_data[i*DW +: DW] = d;
    endtask

    task automatic wait_resp(input int target, input int limit);
        int n = 0;
        while (rsp_cnt < target) begin
            if (n >= limit) begin
                vectors++;
                miscompares++;
                $display("FAIL resp_wait: got %0d responses expected %0d", rsp_cnt, target);
                return;
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_strobe(input int target, input int limit);
        int n = 0;
        while (lb_cnt < target) begin
            if (n >= limit) begin
                vectors++;
                miscompares++;
                $display("FAIL strobe_wait: got %0d strobes expected %0d", lb_cnt, target);
                return;
            end
            @(negedge clk);
            n++;
        end
    endtask

    // Slave model: acknowledges slave_delay cycles after the strobe cycle
    initial begin
        bit w;
        lb_wr_valid = 1'b0;
        lb_rd_valid = 1'b0;
        lb_rd_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst && (lb_wr_en || lb_rd_en) && !slave_mute) begin
                w = lb_wr_en;
                repeat (slave_delay) @(posedge clk);
                #1;
                if (w) lb_wr_valid = 1'b1;
                else begin
                    lb_rd_valid = 1'b1;
                    lb_rd_data  = slave_data;
                end
                @(posedge clk);
                #1;
                lb_wr_valid = 1'b0;
                lb_rd_valid = 1'b0;
                lb_rd_data  = '0;
            end
        end
    end

    // Bus-side monitor: every strobe must match the next expected grant
    initial begin
        lb_exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && (lb_wr_en || lb_rd_en)) begin
                check("strobe_gap_ge4", 64'(cyc - last_strobe >= 4), 64'd1);
                if (lb_q.size() == 0) begin
                    check("unexpected_strobe", 64'(lb_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = lb_q.pop_front();
                    check("lb_wr_en", 64'(lb_wr_en), 64'(e.is_wr));
                    check("lb_rd_en", 64'(lb_rd_en), 64'(!e.is_wr));
                    check("lb_addr", 64'(lb_addr), 64'(e.addr));
                    check("grant_idx", 64'(grant_idx), 64'(e.idx));
                    if (e.is_wr) check("lb_wr_data", 64'(lb_wr_data), 64'(e.data));
                end
                last_strobe = cyc;
                lb_cnt++;
            end
        end
    end

    // Response monitor: every master valid / timeout pulse pops one expectation
    initial begin
        rsp_exp_t e;
        logic [NM-1:0] exp_wr, exp_rd;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && (m_wr_valid != '0 || m_rd_valid != '0 || timeout_err)) begin
                if (rsp_q.size() == 0) begin
                    check("unexpected_rsp", 64'({m_wr_valid, m_rd_valid}), 64'h0);
                end else begin
                    e = rsp_q.pop_front();
                    exp_wr = e.is_wr ? NM'(1) << e.idx : '0;
                    exp_rd = e.is_wr ? '0 : NM'(1) << e.idx;
                    check("m_wr_valid", 64'(m_wr_valid), 64'(exp_wr));
                    check("m_rd_valid", 64'(m_rd_valid), 64'(exp_rd));
                    if (!e.is_wr) check("m_rd_data", 64'(m_rd_data), 64'(e.data));
                    check("timeout_err", 64'(timeout_err), 64'(e.tmo));
                    check("rsp_latency", 64'(cyc - last_strobe), 64'(e.lat));
                end
                rsp_cnt++;
            end
        end
    end

    initial begin
        rst       = 1'b1;
        m_wr_en   = '0;
        m_rd_en   = '0;
        m_addr    = '0;
        m_wr_data = '0;
        repeat (3) @(negedge clk);
        check("rst_lb_wr_en", 64'(lb_wr_en), 64'd0);
        check("rst_lb_rd_en", 64'(lb_rd_en), 64'd0);
        check("rst_lb_addr", 64'(lb_addr), 64'd0);
        check("rst_m_wr_valid", 64'(m_wr_valid), 64'd0);
        check("rst_m_rd_valid", 64'(m_rd_valid), 64'd0);
        check("rst_m_rd_data", 64'(m_rd_data), 64'd0);
        check("rst_timeout_err", 64'(timeout_err), 64'd0);
        check("rst_grant_idx", 64'(grant_idx), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single write from master 0, slave acks 2 cycles after the strobe
        slave_delay = 2;
        push_lb(1, 0, 16'h0010, 32'h1234_5678);
        push_rsp(1, 0, 32'h0, 0, 3);
        set_master(0, 1, 0, 16'h0010, 32'h1234_5678);
        wait_resp(1, 50);
        set_master(0, 0, 0, 16'h0, 32'h0);
        @(negedge clk);

        // Read from master 1
        slave_delay = 1;
        slave_data  = 32'hCAFE_0001;
        push_lb(0, 1, 16'h2004, 32'h0);
        push_rsp(0, 1, 32'hCAFE_0001, 0, 2);
        set_master(1, 0, 1, 16'h2004, 32'h0);
        wait_resp(2, 50);
        set_master(1, 0, 0, 16'h0, 32'h0);
        @(negedge clk);

        // Both masters write continuously: strict alternation starting at 0
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) push_lb(1, 0, 16'h00A0, 32'hA0A0_0000);
            else            push_lb(1, 1, 16'h00A1, 32'hA1A1_1111);
            push_rsp(1, k % 2, 32'h0, 0, 2);
        end
        set_master(0, 1, 0, 16'h00A0, 32'hA0A0_0000);
        set_master(1, 1, 0, 16'h00A1, 32'hA1A1_1111);
        wait_resp(8, 100);
        set_master(0, 0, 0, 16'h0, 32'h0);
        set_master(1, 0, 0, 16'h0, 32'h0);
        @(negedge clk);

        // Write and read together: write wins
        push_lb(1, 0, 16'h0030, 32'h55AA_55AA);
        push_rsp(1, 0, 32'h0, 0, 2);
        set_master(0, 1, 1, 16'h0030, 32'h55AA_55AA);
        wait_resp(9, 50);
        set_master(0, 0, 0, 16'h0, 32'h0);
        @(negedge clk);

        // Hung slave on a read from master 1, then a normal read from master 0
        slave_mute = 1;
        push_lb(0, 1, 16'h0044, 32'h0);
        push_rsp(0, 1, 32'hDEAD_DEAD, 1, 256);
        set_master(1, 0, 1, 16'h0044, 32'h0);
        wait_resp(10, 400);
        set_master(1, 0, 0, 16'h0, 32'h0);
        slave_mute = 0;
        @(negedge clk);
        slave_data = 32'h0BAD_F00D;
        push_lb(0, 0, 16'h0048, 32'h0);
        push_rsp(0, 0, 32'h0BAD_F00D, 0, 2);
        set_master(0, 0, 1, 16'h0048, 32'h0);
        wait_resp(11, 50);
        set_master(0, 0, 0, 16'h0, 32'h0);
        @(negedge clk);

        // Reset while waiting on the slave; pointer must restart at master 0
        slave_mute = 1;
        push_lb(1, 0, 16'h0050, 32'h1111_2222);
        set_master(0, 1, 0, 16'h0050, 32'h1111_2222);
        wait_strobe(lb_cnt + 1, 50);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_lb_wr_en", 64'(lb_wr_en), 64'd0);
        check("midrst_lb_rd_en", 64'(lb_rd_en), 64'd0);
        check("midrst_lb_addr", 64'(lb_addr), 64'd0);
        check("midrst_m_wr_valid", 64'(m_wr_valid), 64'd0);
        check("midrst_m_rd_valid", 64'(m_rd_valid), 64'd0);
        check("midrst_grant_idx", 64'(grant_idx), 64'd0);
        set_master(0, 0, 0, 16'h0, 32'h0);
        @(negedge clk);
        rst        = 1'b0;
        slave_mute = 0;
        push_lb(1, 0, 16'h0060, 32'h6060_6060);
        push_rsp(1, 0, 32'h0, 0, 2);
        push_lb(1, 1, 16'h0064, 32'h6464_6464);
        push_rsp(1, 1, 32'h0, 0, 2);
        set_master(0, 1, 0, 16'h0060, 32'h6060_6060);
        set_master(1, 1, 0, 16'h0064, 32'h6464_6464);
        wait_resp(13, 50);
        set_master(0, 0, 0, 16'h0, 32'h0);
        set_master(1, 0, 0, 16'h0, 32'h0);
        repeat (4) @(negedge clk);

        check("lb_queue_drained", 64'(lb_q.size()), 64'd0);
        check("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
